// File: rtl/mips_pkg.sv
// Shared definitions for the memory-access stage: datapath width, access-size
// encodings and the load/store FSM state type.
package mips_pkg;

  localparam int WORD_SIZE = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10,
    ERR  = 2'b11
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store steering / byte enables on the way out,
// lane extraction and sign/zero extension on the way back.
module lsu_align
  import mips_pkg::*;
(
  input  logic [1:0]           st_size,
  input  logic [1:0]           st_offset,
  input  logic [WORD_SIZE-1:0] store_data,
  output logic [3:0]           st_be,
  output logic [WORD_SIZE-1:0] st_wdata,
  input  logic [1:0]           ld_size,
  input  logic [1:0]           ld_offset,
  input  logic                 ld_sign_ext,
  input  logic [WORD_SIZE-1:0] rdata,
  output logic [WORD_SIZE-1:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = store_data;
    case (st_size)
      SZ_BYTE: begin
        st_be    = 4'b0001 << st_offset;
        st_wdata = {4{store_data[7:0]}};
      end
      SZ_HALF: begin
        st_be    = st_offset[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{store_data[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = store_data;
      end
    endcase
  end

  always_comb begin
    ld_byte = 8'h00;
    case (ld_offset)
      2'd0:    ld_byte = rdata[7:0];
      2'd1:    ld_byte = rdata[15:8];
      2'd2:    ld_byte = rdata[23:16];
      default: ld_byte = rdata[31:24];
    endcase
    ld_half = ld_offset[1] ? rdata[31:16] : rdata[15:0];

    ld_data = rdata;
    case (ld_size)
      SZ_BYTE: ld_data = {{(WORD_SIZE-8){ld_sign_ext & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_data = {{(WORD_SIZE-16){ld_sign_ext & ld_half[15]}}, ld_half};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: runs one load/store against a word-wide valid/ready
// memory port, stalling the core via busy until the access completes.
//
//   state | meaning
//   IDLE  | waiting for a memory op; accepts it combinationally (busy=1)
//   WAIT  | request presented on m_*, held until m_ready
//   RESP  | done pulse, load_data valid
//   ERR   | fault pulse for an illegal access, no memory traffic
module load_store_unit
  import mips_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [1:0]           size,
  input  logic                 sign_ext,
  input  logic [WORD_SIZE-1:0] addr,
  input  logic [WORD_SIZE-1:0] store_data,
  output logic                 busy,
  output logic                 done,
  output logic                 fault,
  output logic [WORD_SIZE-1:0] load_data,
  output logic                 m_valid,
  output logic                 m_we,
  output logic [WORD_SIZE-1:0] m_addr,
  output logic [WORD_SIZE-1:0] m_wdata,
  output logic [3:0]           m_be,
  input  logic                 m_ready,
  input  logic [WORD_SIZE-1:0] m_rdata
);

  lsu_state_t           state;
  logic                 op_read;
  logic [1:0]           size_q;
  logic [1:0]           offset_q;
  logic                 sign_ext_q;
  logic                 accept;
  logic                 illegal;
  logic [3:0]           st_be;
  logic [WORD_SIZE-1:0] st_wdata;
  logic [WORD_SIZE-1:0] ld_data;

  assign accept  = (state == IDLE) && req_valid && (mem_read || mem_write);
  assign illegal = (mem_read && mem_write)
                || (size == SZ_ILL)
                || ((size == SZ_HALF) && addr[0])
                || ((size == SZ_WORD) && (addr[1:0] != 2'b00));

  // Combinational so the core stalls in the same cycle the op is issued.
  assign busy = !reset && (accept || (state == WAIT));

  lsu_align u_align (
    .st_size     (size),
    .st_offset   (addr[1:0]),
    .store_data  (store_data),
    .st_be       (st_be),
    .st_wdata    (st_wdata),
    .ld_size     (size_q),
    .ld_offset   (offset_q),
    .ld_sign_ext (sign_ext_q),
    .rdata       (m_rdata),
    .ld_data     (ld_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      op_read    <= 1'b0;
      size_q     <= SZ_BYTE;
      offset_q   <= 2'b00;
      sign_ext_q <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
      load_data  <= '0;
      m_valid    <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      m_be       <= 4'b0000;
    end else begin
      done  <= 1'b0;
      fault <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (illegal) begin
              state <= ERR;
              fault <= 1'b1;
            end else begin
              state      <= WAIT;
              op_read    <= mem_read;
              size_q     <= size;
              offset_q   <= addr[1:0];
              sign_ext_q <= sign_ext;
              m_valid    <= 1'b1;
              m_we       <= mem_write;
              m_addr     <= {addr[WORD_SIZE-1:2], 2'b00};
              m_be       <= mem_write ? st_be : 4'b1111;
              m_wdata    <= st_wdata;
            end
          end
        end
        WAIT: begin
          if (m_ready) begin
            state     <= RESP;
            done      <= 1'b1;
            m_valid   <= 1'b0;
            m_we      <= 1'b0;
            load_data <= op_read ? ld_data : '0;
          end
        end
        RESP:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
